// File: rtl/writeback_ctrl.sv
// Register-file writeback sequencer: classifies a decoded instruction on start,
// waits for datapath data and issues one or two register writes, then pulses done.
module writeback_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       data_ready,
    output logic [3:0] wr_sel,
    output logic [1:0] wb_src,
    output logic       reg_write,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_A  = 3'd1,
        WRITE_A = 3'd2,
        WAIT_B  = 3'd3,
        WRITE_B = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RD_ALU  = 3'd0,
        CLS_RT_ALU  = 3'd1,
        CLS_RT_MEM  = 3'd2,
        CLS_R31_PC  = 3'd3,
        CLS_R29_ALU = 3'd4,
        CLS_POP     = 3'd5,
        CLS_NOWRITE = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_t;

    localparam logic [3:0] SEL_RT  = 4'b0000;
    localparam logic [3:0] SEL_RD  = 4'b0001;
    localparam logic [3:0] SEL_R29 = 4'b0010;
    localparam logic [3:0] SEL_R31 = 4'b0011;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b10;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_POP   = 6'h1d;
    localparam logic [5:0] OP_PUSH  = 6'h1e;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Last counter value still allowed to wait; reaching it without data aborts.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam int N_IMM  = 5;
    localparam int N_MEM  = 3;
    localparam int N_NOWR = 5;

    localparam logic [5:0] IMM_OPS  [N_IMM]  = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f};
    localparam logic [5:0] MEM_OPS  [N_MEM]  = '{6'h20, 6'h21, 6'h23};
    localparam logic [5:0] NOWR_OPS [N_NOWR] = '{6'h02, 6'h04, 6'h05, 6'h28, 6'h29};

    state_t     state_reg, state_next;
    cls_t       cls_reg, cls_next, start_cls;
    logic [7:0] cnt_reg, cnt_next;
    logic [1:0] err_code;

    logic [3:0] wr_sel_reg, wr_sel_next;
    logic [1:0] wb_src_reg, wb_src_next;
    logic       reg_write_reg, reg_write_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [1:0] err_reg, err_next;

    logic [N_IMM-1:0]  imm_hit;
    logic [N_MEM-1:0]  mem_hit;
    logic [N_NOWR-1:0] nowr_hit;

    // Opcode match vectors against the per-class opcode tables.
    genvar gi;
    generate
        for (gi = 0; gi < N_IMM; gi++) begin : g_imm
            assign imm_hit[gi] = (opcode == IMM_OPS[gi]);
        end
        for (gi = 0; gi < N_MEM; gi++) begin : g_mem
            assign mem_hit[gi] = (opcode == MEM_OPS[gi]);
        end
        for (gi = 0; gi < N_NOWR; gi++) begin : g_nowr
            assign nowr_hit[gi] = (opcode == NOWR_OPS[gi]);
        end
    endgenerate

    always_comb begin
        start_cls = CLS_ILLEGAL;
        if (opcode == OP_RTYPE) begin
            start_cls = (funct == FN_JR) ? CLS_NOWRITE : CLS_RD_ALU;
        end else if (|imm_hit) begin
            start_cls = CLS_RT_ALU;
        end else if (|mem_hit) begin
            start_cls = CLS_RT_MEM;
        end else if (opcode == OP_JAL) begin
            start_cls = CLS_R31_PC;
        end else if (opcode == OP_PUSH) begin
            start_cls = CLS_R29_ALU;
        end else if (opcode == OP_POP) begin
            start_cls = CLS_POP;
        end else if (|nowr_hit || opcode == 6'h2b) begin
            start_cls = CLS_NOWRITE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cls_reg       <= CLS_NOWRITE;
            cnt_reg       <= 8'd0;
            wr_sel_reg    <= SEL_RT;
            wb_src_reg    <= SRC_ALU;
            reg_write_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            cls_reg       <= cls_next;
            cnt_reg       <= cnt_next;
            wr_sel_reg    <= wr_sel_next;
            wb_src_reg    <= wb_src_next;
            reg_write_reg <= reg_write_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // Next state, counter and the error code carried into DONE.
    always_comb begin
        state_next = state_reg;
        cls_next   = cls_reg;
        cnt_next   = cnt_reg;
        err_code   = ERR_OK;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cls_next = start_cls;
                    if (start_cls == CLS_ILLEGAL) begin
                        state_next = DONE;
                        err_code   = ERR_ILLEGAL;
                    end else if (start_cls == CLS_NOWRITE) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT_A;
                        cnt_next   = 8'd0;
                    end
                end
            end
            WAIT_A, WAIT_B: begin
                if (data_ready) begin
                    state_next = (state_reg == WAIT_A) ? WRITE_A : WRITE_B;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    err_code   = ERR_TIMEOUT;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            WRITE_A: begin
                if (cls_reg == CLS_POP) begin
                    state_next = WAIT_B;
                    cnt_next   = 8'd0;
                end else begin
                    state_next = DONE;
                end
            end
            WRITE_B: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register with it.
    always_comb begin
        wr_sel_next    = SEL_RT;
        wb_src_next    = SRC_ALU;
        reg_write_next = 1'b0;
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
        err_next       = (state_next == DONE) ? err_code : ERR_OK;
        case (state_next)
            WAIT_A, WRITE_A: begin
                reg_write_next = (state_next == WRITE_A);
                case (cls_next)
                    CLS_RD_ALU:  begin wr_sel_next = SEL_RD;  wb_src_next = SRC_ALU; end
                    CLS_RT_ALU:  begin wr_sel_next = SEL_RT;  wb_src_next = SRC_ALU; end
                    CLS_RT_MEM:  begin wr_sel_next = SEL_RT;  wb_src_next = SRC_MEM; end
                    CLS_R31_PC:  begin wr_sel_next = SEL_R31; wb_src_next = SRC_PC;  end
                    CLS_R29_ALU: begin wr_sel_next = SEL_R29; wb_src_next = SRC_ALU; end
                    CLS_POP:     begin wr_sel_next = SEL_RT;  wb_src_next = SRC_MEM; end
                    default:     begin wr_sel_next = SEL_RT;  wb_src_next = SRC_ALU; end
                endcase
            end
            WAIT_B, WRITE_B: begin
                // Only pop has a second step: stack-pointer update from the ALU.
                reg_write_next = (state_next == WRITE_B);
                wr_sel_next    = SEL_R29;
                wb_src_next    = SRC_ALU;
            end
            default: begin
                wr_sel_next = SEL_RT;
                wb_src_next = SRC_ALU;
            end
        endcase
    end

    assign wr_sel    = wr_sel_reg;
    assign wb_src    = wb_src_reg;
    assign reg_write = reg_write_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: doc/writeback_ctrl.md
WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max consecutive WAIT cycles before abort (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port start  input  1  one-cycle pulse; opcode/funct valid for the decoded instruction.
REQ-005 SHALL have port opcode  input  6  instruction bits 31:26, sampled only with start.
REQ-006 SHALL have port funct  input  6  instruction bits 5:0, sampled only with start.
REQ-007 SHALL have port data_ready  input  1  write data for the pending write step is valid on the datapath.
REQ-008 SHALL have port wr_sel  output  4  write-register mux select: 0000 rt, 0001 rd, 0010 reg 29, 0011 reg 31.
REQ-009 SHALL have port wb_src  output  2  write-data source: 00 ALU, 01 memory, 10 PC.
REQ-010 SHALL have port reg_write  output  1  register-file write enable.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  2  valid with done: 00 ok, 01 illegal opcode, 10 timeout.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_A, WRITE_A, WAIT_B, WRITE_B, DONE; all outputs registered.
REQ-015 SHALL classify on start in IDLE: opcode 0x00 with funct != 0x08 -> rd/ALU; opcode 0x08,0x09,0x0a,0x0c,0x0f -> rt/ALU; 0x20,0x21,0x23 -> rt/MEM; 0x03 -> reg31/PC; 0x1e (push) -> reg29/ALU; 0x1d (pop) -> rt/MEM then reg29/ALU.
REQ-016 SHALL classify as no-write: opcode 0x00 with funct 0x08, and opcodes 0x02, 0x04, 0x05, 0x28, 0x29, 0x2b; these go IDLE -> DONE with err=00.
REQ-017 SHALL treat any other opcode as illegal: IDLE -> DONE with err=01, no reg_write.
REQ-018 SHALL latch the class on start; opcode/funct changes afterwards have no effect.
REQ-019 SHALL in WAIT_A/WAIT_B drive wr_sel/wb_src of the pending step, reg_write=0; data_ready high -> WRITE_x next cycle.
REQ-020 SHALL in WRITE_x assert reg_write=1 for exactly one cycle with wr_sel/wb_src of that step held stable.
REQ-021 SHALL move WRITE_A -> WAIT_B for pop only, otherwise WRITE_A -> DONE; WRITE_B -> DONE.
REQ-022 SHALL assert done=1 for one cycle in DONE, then return to IDLE; err held 00 outside DONE.
REQ-023 SHALL count consecutive WAIT cycles with an 8-bit counter cleared on entering each WAIT state; when the count reaches TIMEOUT without data_ready, go to DONE with err=10 and no write.
REQ-024 SHALL ignore start whenever busy=1 and ignore data_ready outside WAIT states.
REQ-025 SHALL drive wr_sel=0000, wb_src=00 in IDLE and DONE.
REQ-026 SHALL give single-write latency: start at cycle 0, data_ready at cycle 1 -> reg_write at cycle 2, done at cycle 3.
REQ-027 SHALL allow start in the cycle after done (back-to-back instructions).

Reset
REQ-028 SHALL on reset, asynchronously, force state IDLE, counter 0, reg_write=0, busy=0, done=0, err=00, wr_sel=0000, wb_src=00.
REQ-029 SHALL abandon any in-progress sequence on reset, including mid-WRITE; no partial second write of pop afterwards.

Verification
REQ-030 SHALL verify: start, opcode 0x00 funct 0x20, data_ready at cycle 1 -> cycle 2 reg_write=1 wr_sel=0001 wb_src=00; cycle 3 done=1 err=00.
REQ-031 SHALL verify: start, opcode 0x1d, data_ready at cycles 1 and 3 -> reg_write cycle 2 (0000/01) and cycle 4 (0010/00); done at cycle 5.
REQ-032 SHALL verify: start, opcode 0x03, data_ready at cycle 4 -> WAIT cycles 1-4, reg_write cycle 5 wr_sel=0011 wb_src=10, done cycle 6.
REQ-033 SHALL verify: start, opcode 0x2b -> done at cycle 1, err=00, reg_write never asserted; opcode 0x3f -> done cycle 1, err=01.
REQ-034 SHALL verify: start, opcode 0x23, data_ready held low, TIMEOUT=16 -> done with err=10 after 16 WAIT cycles, reg_write never asserted.
REQ-035 SHALL verify: pop, reset asserted in WAIT_B -> outputs cleared same cycle without an edge, no further reg_write; new start also ignored while busy.
